// File: rtl/lzc_norm_pipe_if.sv
// Handshake bundle for the leading-zero count / normalize pipeline.
// The slave side is the pipeline; the master side drives beats in and takes results out.
interface lzc_norm_pipe_if #(
  parameter int W     = 32,
  parameter int TAG_W = 8
);
  localparam int L = $clog2(W);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_norm;
  logic [L-1:0]     out_cnt;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_norm, out_cnt, out_zero, out_tag
  );

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_norm, out_cnt, out_zero, out_tag
  );
endinterface

// File: rtl/lzc_norm_pipe.sv
// Pipelined leading-zero counter and left-normalizer.
// Stage k tests the top 2^(L-1-k) bits and shifts them out when they are all zero.
// Each stage sets a different count bit, so the partial counts combine by OR.
// The pipeline collapses bubbles: an empty stage always accepts from the one before it.
module lzc_norm_pipe #(
  parameter int W     = 32,
  parameter int TAG_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  lzc_norm_pipe_if.slave bus
);
  localparam int L = $clog2(W);

  logic [L-1:0]     valid_q;
  logic [L-1:0]     valid_d;
  logic [W-1:0]     data_q [L];
  logic [W-1:0]     data_d [L];
  logic [L-1:0]     cnt_q  [L];
  logic [L-1:0]     cnt_d  [L];
  logic [L-1:0]     zero_q;
  logic [L-1:0]     zero_d;
  logic [TAG_W-1:0] tag_q  [L];
  logic [TAG_W-1:0] tag_d  [L];
  logic [L-1:0]     adv;

  logic             src_valid;
  logic [W-1:0]     src_data;
  logic [L-1:0]     src_cnt;
  logic             src_zero;
  logic [TAG_W-1:0] src_tag;
  logic             top_zero;
  logic [L-1:0]     cnt_bit;

  // Advance chain from the output back to s0, then next-state for every stage.
  always_comb begin
    adv      = '0;
    adv[L-1] = !valid_q[L-1] || bus.out_ready;
    for (int k = L - 2; k >= 0; k--) begin
      adv[k] = !valid_q[k] || adv[k+1];
    end

    src_valid = bus.in_valid;
    src_data  = bus.in_data;
    src_cnt   = '0;
    src_zero  = ~|bus.in_data;
    src_tag   = bus.in_tag;
    top_zero  = 1'b0;
    cnt_bit   = '0;

    for (int k = 0; k < L; k++) begin
      valid_d[k] = valid_q[k];
      data_d[k]  = data_q[k];
      cnt_d[k]   = cnt_q[k];
      zero_d[k]  = zero_q[k];
      tag_d[k]   = tag_q[k];

      top_zero         = (src_data >> (W - (1 << (L - 1 - k)))) == '0;
      cnt_bit          = '0;
      cnt_bit[L-1-k]   = top_zero;

      if (adv[k]) begin
        valid_d[k] = src_valid;
        // Payload only loads with a real beat; an emptied stage keeps stale data.
        if (src_valid) begin
          data_d[k] = top_zero ? (src_data << (1 << (L - 1 - k))) : src_data;
          cnt_d[k]  = src_cnt | cnt_bit;
          zero_d[k] = src_zero;
          tag_d[k]  = src_tag;
        end
      end

      src_valid = valid_q[k];
      src_data  = data_q[k];
      src_cnt   = cnt_q[k];
      src_zero  = zero_q[k];
      src_tag   = tag_q[k];
    end
  end

  // Stage registers; reset empties the pipe and clears every payload field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      zero_q  <= '0;
      for (int k = 0; k < L; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      zero_q  <= zero_d;
      for (int k = 0; k < L; k++) begin
        data_q[k] <= data_d[k];
        cnt_q[k]  <= cnt_d[k];
        tag_q[k]  <= tag_d[k];
      end
    end
  end

  assign bus.in_ready  = adv[0] && !rst;
  assign bus.out_valid = valid_q[L-1];
  assign bus.out_norm  = data_q[L-1];
  assign bus.out_cnt   = cnt_q[L-1];
  assign bus.out_zero  = zero_q[L-1];
  assign bus.out_tag   = tag_q[L-1];
endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Directed and randomized checks of lzc_norm_pipe at W=32, plus a W=8 instance.
module tb_lzc_norm_pipe;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lzc_norm_pipe_if #(.W(32), .TAG_W(8)) bus32 ();
  lzc_norm_pipe_if #(.W(8),  .TAG_W(8)) bus8  ();

  lzc_norm_pipe #(.W(32), .TAG_W(8)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  lzc_norm_pipe #(.W(8),  .TAG_W(8)) u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct packed {
    logic [31:0] norm;
    logic [4:0]  cnt;
    logic        zero;
    logic [7:0]  tag;
  } exp_t;

  exp_t        sb_q [$];
  exp_t        e;
  int          n_chk = 0;
  int          n_err = 0;
  int          n_out = 0;
  logic        stall_q = 1'b0;
  logic [31:0] hold_norm;
  logic [4:0]  hold_cnt;
  logic        hold_zero;
  logic [7:0]  hold_tag;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: scan for the highest set bit, no shift levels.
  function automatic exp_t model(input logic [31:0] d, input logic [7:0] t);
    exp_t r;
    int   lz;
    lz = 31;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) lz = 31 - i;
    end
    r.norm = d << lz;
    r.cnt  = lz[4:0];
    r.zero = (d == 32'd0);
    r.tag  = t;
    return r;
  endfunction

  function automatic logic [31:0] rnd_data();
    logic [31:0] v;
    v = $urandom;
    return v >> $urandom_range(0, 32);
  endfunction

  // Scoreboard and stall-hold monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", 64'(bus32.out_valid), 64'd1);
        chk("hold_norm",  64'(bus32.out_norm),  64'(hold_norm));
        chk("hold_cnt",   64'(bus32.out_cnt),   64'(hold_cnt));
        chk("hold_zero",  64'(bus32.out_zero),  64'(hold_zero));
        chk("hold_tag",   64'(bus32.out_tag),   64'(hold_tag));
      end
      if (bus32.out_valid && bus32.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_extra", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_tag",  64'(bus32.out_tag),  64'(e.tag));
          chk("sb_norm", 64'(bus32.out_norm), 64'(e.norm));
          chk("sb_cnt",  64'(bus32.out_cnt),  64'(e.cnt));
          chk("sb_zero", 64'(bus32.out_zero), 64'(e.zero));
          n_out++;
        end
      end
      if (bus32.in_valid && bus32.in_ready) sb_q.push_back(model(bus32.in_data, bus32.in_tag));
      stall_q   = bus32.out_valid && !bus32.out_ready;
      hold_norm = bus32.out_norm;
      hold_cnt  = bus32.out_cnt;
      hold_zero = bus32.out_zero;
      hold_tag  = bus32.out_tag;
    end
  end

  task automatic single(input string tag, input logic [31:0] d, input logic [4:0] ecnt,
                        input logic [31:0] enorm, input logic ezero);
    int lat;
    bus32.out_ready = 1'b1;
    bus32.in_valid  = 1'b1;
    bus32.in_data   = d;
    bus32.in_tag    = 8'h3C;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    lat = 1;
    while (!bus32.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"},  64'(lat), 64'd5);
    chk({tag, "_cnt"},  64'(bus32.out_cnt),  64'(ecnt));
    chk({tag, "_norm"}, 64'(bus32.out_norm), 64'(enorm));
    chk({tag, "_zero"}, 64'(bus32.out_zero), 64'(ezero));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int n;
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    n = 0;
    while ((sb_q.size() != 0 || bus32.out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   acc;
    int   sent;
    int   cyc;
    int   nv;
    int   first_v;
    int   out_base;
    logic ok;
    logic [7:0] tg;

    rst = 1'b1;
    bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_tag = '0; bus32.out_ready = 1'b1;
    bus8.in_valid  = 1'b0; bus8.in_data  = '0; bus8.in_tag  = '0; bus8.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus32.out_valid), 64'd0);
    chk("rst_norm",  64'(bus32.out_norm),  64'd0);
    chk("rst_cnt",   64'(bus32.out_cnt),   64'd0);
    chk("rst_zero",  64'(bus32.out_zero),  64'd0);
    chk("rst_tag",   64'(bus32.out_tag),   64'd0);
    chk("rst_ready", 64'(bus32.in_ready),  64'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 64'(bus32.in_ready), 64'd1);
    @(posedge clk); #1;

    single("d10000", 32'h0001_0000, 5'd15, 32'h8000_0000, 1'b0);
    single("d8000",  32'h8000_0000, 5'd0,  32'h8000_0000, 1'b0);
    single("df00",   32'h0000_0F00, 5'd20, 32'hF000_0000, 1'b0);
    single("d1",     32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
    single("d0",     32'h0000_0000, 5'd31, 32'h0000_0000, 1'b1);

    // W=8 instance
    for (int v = 0; v < 2; v++) begin
      bus8.in_data  = (v == 0) ? 8'h10 : 8'h00;
      bus8.in_tag   = 8'(v);
      bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      lat = 1;
      while (!bus8.out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("w8_lat",  64'(lat), 64'd3);
      chk("w8_cnt",  64'(bus8.out_cnt),  (v == 0) ? 64'd3 : 64'd7);
      chk("w8_norm", 64'(bus8.out_norm), (v == 0) ? 64'h80 : 64'h0);
      chk("w8_zero", 64'(bus8.out_zero), (v == 0) ? 64'd0 : 64'd1);
      chk("w8_tag",  64'(bus8.out_tag),  64'(v));
      @(posedge clk); #1;
    end

    // 64-beat stream at full rate
    bus32.out_ready = 1'b1;
    bus32.in_valid  = 1'b1;
    bus32.in_data   = rnd_data();
    bus32.in_tag    = 8'd0;
    nv = 0;
    first_v = 0;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk); #1;
      if (bus32.out_valid) begin
        nv++;
        if (first_v == 0) first_v = c;
      end
      if (c < 64) begin
        bus32.in_data = rnd_data();
        bus32.in_tag  = 8'(c);
      end else begin
        bus32.in_valid = 1'b0;
      end
    end
    chk("str_first", 64'(first_v), 64'd5);
    chk("str_count", 64'(nv), 64'd64);
    drain("str_drain");

    // Backpressure: out_ready low for 10 cycles, in_valid held high
    bus32.out_ready = 1'b0;
    bus32.in_valid  = 1'b1;
    tg = 8'h40;
    bus32.in_data = rnd_data();
    bus32.in_tag  = tg;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      ok = bus32.in_ready;
      @(posedge clk); #1;
      if (ok) begin
        acc++;
        tg++;
        bus32.in_data = rnd_data();
        bus32.in_tag  = tg;
      end
    end
    #1;
    chk("bp_accepted", 64'(acc), 64'd5);
    chk("bp_ready",    64'(bus32.in_ready), 64'd0);
    chk("bp_valid",    64'(bus32.out_valid), 64'd1);
    chk("bp_head_tag", 64'(bus32.out_tag), 64'h40);
    out_base = n_out;
    drain("bp_drain");
    chk("bp_outs", 64'(n_out - out_base), 64'd5);

    // Random valid/ready, 2000 beats
    bus32.in_data = rnd_data();
    bus32.in_tag  = 8'd0;
    sent = 0;
    cyc  = 0;
    out_base = n_out;
    while (sent < 2000 && cyc < 20000) begin
      bus32.in_valid  = 1'($urandom_range(0, 1));
      bus32.out_ready = 1'($urandom_range(0, 1));
      #1;
      ok = bus32.in_valid && bus32.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (ok) begin
        sent++;
        bus32.in_data = rnd_data();
        bus32.in_tag  = sent[7:0];
      end
    end
    chk("rnd_sent", 64'(sent), 64'd2000);
    drain("rnd_drain");
    chk("rnd_outs", 64'(n_out - out_base), 64'd2000);

    // Reset with three beats in flight
    bus32.out_ready = 1'b0;
    bus32.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus32.in_data = rnd_data() | 32'h0000_0100;
      bus32.in_tag  = 8'(8'h80 + i);
      @(posedge clk); #1;
    end
    bus32.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_valid", 64'(bus32.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus32.out_valid), 64'd0);
    chk("mid_rst_norm",  64'(bus32.out_norm),  64'd0);
    chk("mid_rst_cnt",   64'(bus32.out_cnt),   64'd0);
    chk("mid_rst_zero",  64'(bus32.out_zero),  64'd0);
    chk("mid_rst_tag",   64'(bus32.out_tag),   64'd0);
    chk("mid_rst_ready", 64'(bus32.in_ready),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus32.out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 64'(bus32.in_ready), 64'd1);
    bus32.in_valid = 1'b1;
    bus32.in_data  = 32'h0000_0F00;
    bus32.in_tag   = 8'hA5;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    lat = 1;
    while (!bus32.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("post_rst_lat", 64'(lat), 64'd5);
    chk("post_rst_tag", 64'(bus32.out_tag), 64'hA5);
    chk("post_rst_cnt", 64'(bus32.out_cnt), 64'd20);
    drain("post_rst_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
